// File: rtl/decoder_rr_arbiter4.sv
// Four-requester round-robin arbiter with a bounded hold time. It registers the
// winner index and drives a 2x4-decoded one-hot grant.
module decoder_rr_arbiter4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             pick_ok;
  logic [1:0]       pick_idx;

  // Searching last+1 .. last+4 visits the previous owner last, so a forced
  // release naturally prefers any other requester and re-grants the owner only
  // when it is alone.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic       found;
    logic [1:0] win;
    logic [1:0] c;
    found = 1'b0;
    win   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      c = last + k[1:0];
      if (r[c] && !found) begin
        found = 1'b1;
        win   = c;
      end
    end
    return {found, win};
  endfunction

  function automatic logic [3:0] dec2x4(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  always_comb begin
    {pick_ok, pick_idx} = rr_pick(req, last_q);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && pick_ok) begin
          state_d = BUSY;
          idx_d   = pick_idx;
          last_d  = pick_idx;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (req[idx_q] && (cnt_q < HOLD_LAST)) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          // Owner still requesting here means the hold limit was reached.
          tmo_d = req[idx_q];
          cnt_d = '0;
          if (en && pick_ok) begin
            idx_d  = pick_idx;
            last_d = pick_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    gnt_d = (state_d == BUSY) ? dec2x4(idx_d) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      gnt_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = (state_q == BUSY);
  assign timeout   = tmo_q;

endmodule

// File: tb/tb_decoder_rr_arbiter4.sv
// Directed bench for decoder_rr_arbiter4: stimulus pushes hand-computed
// expectations into a scoreboard queue that a monitor drains every cycle.
module tb_decoder_rr_arbiter4;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
    logic       tmo;
    bit         chk_idx;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  decoder_rr_arbiter4 #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs for one cycle and queue the outputs expected after its edge.
  task automatic step(input logic r, input logic e, input logic [3:0] rq,
                      input logic [3:0] g, input logic [1:0] ix, input logic v,
                      input logic t, input bit ci, input string nm);
    exp_t x;
    @(negedge clk);
    rst = r;
    en  = e;
    req = rq;
    x.gnt = g; x.idx = ix; x.vld = v; x.tmo = t; x.chk_idx = ci; x.name = nm;
    sb.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      checks++;
      if (gnt !== cur.gnt) begin
        errors++;
        $display("FAIL %s gnt: got %b expected %b", cur.name, gnt, cur.gnt);
      end
      checks++;
      if (gnt_valid !== cur.vld) begin
        errors++;
        $display("FAIL %s gnt_valid: got %b expected %b", cur.name, gnt_valid, cur.vld);
      end
      checks++;
      if (timeout !== cur.tmo) begin
        errors++;
        $display("FAIL %s timeout: got %b expected %b", cur.name, timeout, cur.tmo);
      end
      if (cur.chk_idx) begin
        checks++;
        if (gnt_idx !== cur.idx) begin
          errors++;
          $display("FAIL %s gnt_idx: got %0d expected %0d", cur.name, gnt_idx, cur.idx);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", sb.size());
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    req = 4'b0000;

    // Rotation through all four requesters.
    step(1, 1, 4'b1111, 4'b0000, 2'd0, 0, 0, 1, "reset");
    step(0, 1, 4'b1111, 4'b0001, 2'd0, 1, 0, 1, "first_grant");
    step(0, 1, 4'b1110, 4'b0010, 2'd1, 1, 0, 1, "rot_1");
    step(0, 1, 4'b1100, 4'b0100, 2'd2, 1, 0, 1, "rot_2");
    step(0, 1, 4'b1000, 4'b1000, 2'd3, 1, 0, 1, "rot_3");
    step(0, 1, 4'b0001, 4'b0001, 2'd0, 1, 0, 1, "rot_wrap");
    step(0, 1, 4'b0000, 4'b0000, 2'd0, 0, 0, 0, "idle_after_wrap");

    // Two competing requesters alternate every MAX_HOLD cycles.
    step(1, 1, 4'b0101, 4'b0000, 2'd0, 0, 0, 1, "reset2");
    for (int k = 1; k <= 8; k++)
      step(0, 1, 4'b0101, 4'b0001, 2'd0, 1, 0, 1, "hold_r0");
    step(0, 1, 4'b0101, 4'b0100, 2'd2, 1, 1, 1, "force_to_r2");
    for (int k = 2; k <= 8; k++)
      step(0, 1, 4'b0101, 4'b0100, 2'd2, 1, 0, 1, "hold_r2");
    step(0, 1, 4'b0101, 4'b0001, 2'd0, 1, 1, 1, "force_to_r0");
    step(0, 1, 4'b0101, 4'b0001, 2'd0, 1, 0, 1, "after_force_r0");

    // Sole requester re-granted on timeout with no gap.
    step(1, 1, 4'b0100, 4'b0000, 2'd0, 0, 0, 1, "reset3");
    for (int k = 1; k <= 20; k++)
      step(0, 1, 4'b0100, 4'b0100, 2'd2, 1, ((k == 9) || (k == 17)) ? 1'b1 : 1'b0, 1, "sole_hold");

    // Release to empty, then round-robin resumes after the last owner.
    step(1, 1, 4'b0010, 4'b0000, 2'd0, 0, 0, 1, "reset4");
    step(0, 1, 4'b0010, 4'b0010, 2'd1, 1, 0, 1, "grant_r1");
    step(0, 1, 4'b0000, 4'b0000, 2'd0, 0, 0, 0, "release_empty");
    step(0, 1, 4'b1001, 4'b1000, 2'd3, 1, 0, 1, "rr_after_r1");

    // en=0 does not cut a grant, but blocks the re-grant at timeout.
    step(1, 1, 4'b0011, 4'b0000, 2'd0, 0, 0, 1, "reset5");
    step(0, 1, 4'b0011, 4'b0001, 2'd0, 1, 0, 1, "grant_r0_en");
    for (int k = 2; k <= 8; k++)
      step(0, 0, 4'b0011, 4'b0001, 2'd0, 1, 0, 1, "hold_en0");
    step(0, 0, 4'b0011, 4'b0000, 2'd0, 0, 1, 0, "timeout_en0_idle");
    step(0, 0, 4'b0011, 4'b0000, 2'd0, 0, 0, 0, "idle_en0");
    step(0, 1, 4'b0011, 4'b0010, 2'd1, 1, 0, 1, "en_back_r1");

    // Reset in the middle of a grant.
    step(0, 1, 4'b1111, 4'b0010, 2'd1, 1, 0, 1, "busy_before_rst");
    step(1, 1, 4'b1111, 4'b0000, 2'd0, 0, 0, 1, "rst_mid_grant");
    step(0, 1, 4'b1111, 4'b0001, 2'd0, 1, 0, 1, "grant_after_rst");

    for (int w = 0; w < 10 && sb.size() > 0; w++)
      @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
